// File: rtl/op_seq_pkg.sv
// op_seq_pkg: shared types and LED constants for the op_entry_sequencer slice
package op_seq_pkg;
  typedef enum logic [2:0] {A_LO, A_HI, B_LO, B_HI, EXEC, SHOW_L, SHOW_M} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_OR, OP_AND} op_t;
  localparam logic [7:0] LEDG_A_LO = 8'h80;
  localparam logic [7:0] LEDG_A_HI = 8'h40;
  localparam logic [7:0] LEDG_B_LO = 8'h20;
  localparam logic [7:0] LEDG_B_HI = 8'h10;
  localparam logic [7:0] LEDG_EXEC = 8'h08;
  localparam logic [7:0] LEDG_SHOW_L = 8'h02;
  localparam logic [7:0] LEDG_SHOW_M = 8'h01;
  localparam int LEDG_ERR = 2;
  function automatic logic [7:0] ledg_of(state_t s);
    return s == A_LO ? LEDG_A_LO : s == A_HI ? LEDG_A_HI : s == B_LO ? LEDG_B_LO :
           s == B_HI ? LEDG_B_HI : s == EXEC ? LEDG_EXEC : s == SHOW_L ? LEDG_SHOW_L : LEDG_SHOW_M;
  endfunction
endpackage

// File: rtl/op_entry_sequencer_if.sv
// op_entry_sequencer_if: load-strobe bus and ALU start/done handshake to the datapath
//   master (sequencer): drives ld_data, ld_a_lo/hi, ld_b_lo/hi, clr, alu_op, alu_start
//   slave (datapath):   drives alu_done, alu_result
interface op_entry_sequencer_if;
  import op_seq_pkg::*;
  logic [15:0] ld_data;
  logic ld_a_lo, ld_a_hi, ld_b_lo, ld_b_hi, clr;
  op_t alu_op;
  logic alu_start, alu_done;
  logic [31:0] alu_result;
  modport master(output ld_data, ld_a_lo, ld_a_hi, ld_b_lo, ld_b_hi, clr, alu_op, alu_start,
                 input alu_done, alu_result);
  modport slave(input ld_data, ld_a_lo, ld_a_hi, ld_b_lo, ld_b_hi, clr, alu_op, alu_start,
                output alu_done, alu_result);
endinterface

// File: rtl/op_entry_sequencer_btn_conditioner.sv
// btn_conditioner: sync, optional debounce and rising-edge pulse for one raw button
//   clk, rst_n: clock and async active-low reset
//   btn: raw asynchronous level; ev: one-cycle pulse per accepted press
//   OP_SEQ_DEBOUNCE_EN: insert a DEBOUNCE_CYCLES stability filter after the synchronizer
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic ev
);
`ifdef OP_SEQ_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  logic s0, s1, lvl, lvl_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s0, s1} <= '0;
    else {s0, s1} <= {btn, s0};
  if (DB_EN && DEBOUNCE_CYCLES > 0) begin : g_db
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;
    // lvl follows s1 only after it has differed for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s1 == lvl) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= s1;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
  end else begin : g_raw
    assign lvl = s1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {lvl_q, ev} <= '0;
    else {lvl_q, ev} <= {lvl, lvl & ~lvl_q};
endmodule

// File: rtl/op_entry_sequencer.sv
// op_entry_sequencer: button-driven operand entry, ALU launch and result paging
//   clk, rst_n: clock and async active-low reset
//   btn_change/btn_enter/btn_cancel: raw buttons; sw[17:2] operand half, sw[1:0] opcode
//   bus (master): load strobes, clr, alu_op/alu_start out; alu_done/alu_result in
//   ledr/ledg: LED drive (ledg one-hot state, bit 2 error); busy: high during EXEC
//   OP_SEQ_DEBOUNCE_EN: enables button debouncing of DEBOUNCE_CYCLES
module op_entry_sequencer
  import op_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int EXEC_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_change,
  input  logic btn_enter,
  input  logic btn_cancel,
  input  logic [17:0] sw,
  op_entry_sequencer_if.master bus,
  output logic [17:0] ledr,
  output logic [7:0] ledg,
  output logic busy
);
  localparam int TW = $clog2(EXEC_TIMEOUT + 1);
  state_t st, nx;
  logic ev_c, ev_e, ev_x, entry, run, tmo, start_d, pend, err;
  logic [3:0] ld_d;
  logic [TW-1:0] cnt;
  logic [31:0] result;
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chg (.clk(clk), .rst_n(rst_n), .btn(btn_change), .ev(ev_c));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ent (.clk(clk), .rst_n(rst_n), .btn(btn_enter), .ev(ev_e));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_can (.clk(clk), .rst_n(rst_n), .btn(btn_cancel), .ev(ev_x));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= A_LO;
    else st <= nx;
  // pend marks the extra EXEC cycle after a B_HI enter, so ld_b_hi lands before alu_start
  always_comb begin
    entry = st inside {A_LO, A_HI, B_LO, B_HI};
    run = st == EXEC && !pend;
    tmo = run && cnt == TW'(EXEC_TIMEOUT);
    nx = ev_x ? A_LO :
         (entry && ev_e) ? EXEC :
         (entry && ev_c) ? (st == B_HI ? B_HI : state_t'(st + 3'd1)) :
         (run && (bus.alu_done || tmo)) ? SHOW_L :
         (st == SHOW_L && ev_e) ? SHOW_M :
         (st == SHOW_M && ev_e) ? SHOW_L : st;
  end
  // ld_d = {a_lo, a_hi, b_lo, b_hi}
  always_comb begin
    ld_d = (ev_x || !entry) ? 4'b0 : ev_e ? {3'b0, st == B_HI} : ev_c ? 4'b1000 >> st : 4'b0;
    start_d = !ev_x && ((entry && ev_e && st != B_HI) || pend);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {bus.ld_a_lo, bus.ld_a_hi, bus.ld_b_lo, bus.ld_b_hi} <= '0;
      bus.ld_data <= '0;
      bus.clr <= 1'b0;
      bus.alu_op <= OP_ADD;
      bus.alu_start <= 1'b0;
      pend <= 1'b0;
      cnt <= '0;
      err <= 1'b0;
      result <= '0;
      busy <= 1'b0;
      ledg <= LEDG_A_LO;
      ledr <= '0;
    end else begin
      {bus.ld_a_lo, bus.ld_a_hi, bus.ld_b_lo, bus.ld_b_hi} <= ld_d;
      if (|ld_d) bus.ld_data <= sw[17:2];
      bus.clr <= ev_x;
      if (!ev_x && entry && ev_e) bus.alu_op <= op_t'(sw[1:0]);
      bus.alu_start <= start_d;
      pend <= !ev_x && entry && ev_e && st == B_HI;
      cnt <= start_d ? TW'(1) : cnt + 1'b1;
      err <= ev_x ? 1'b0 : (run && bus.alu_done) ? 1'b0 : tmo ? 1'b1 : err;
      result <= ev_x ? '0 : (run && bus.alu_done) ? bus.alu_result : tmo ? '0 : result;
      busy <= nx == EXEC;
      ledg <= ledg_of(st) | (8'(err) << LEDG_ERR);
      ledr <= st == EXEC ? '0 : st == SHOW_L ? {result[15:0], sw[1:0]} :
              st == SHOW_M ? {result[31:16], sw[1:0]} : sw;
    end
endmodule

// File: tb/tb_op_entry_sequencer.sv
// tb_op_entry_sequencer: directed stimulus with a behavioural per-cycle model and literal checks
module tb_op_entry_sequencer;
  localparam int TMO = 255;
  logic clk = 0, rst_n = 0;
  logic btn_change = 0, btn_enter = 0, btn_cancel = 0;
  logic [17:0] sw = '0;
  logic [17:0] ledr;
  logic [7:0] ledg;
  logic busy;
  int vectors = 0, miscompares = 0;
  op_entry_sequencer_if bus();
  op_entry_sequencer #(.DEBOUNCE_CYCLES(4), .EXEC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .btn_change(btn_change), .btn_enter(btn_enter),
    .btn_cancel(btn_cancel), .sw(sw), .bus(bus), .ledr(ledr), .ledg(ledg), .busy(busy));
  always #5 clk = ~clk;

  // model: modes 0..3 entry halves, 4 exec, 5 show low, 6 show high
  int mode = 0, age = 0, pm;
  bit pre = 0, err = 0, perr, ec, ee, ex;
  logic [31:0] res = '0, pres;
  logic [3:0] hc = '0, he = '0, hx = '0;
  logic [17:0] e_ledr = '0;
  logic [7:0] e_ledg = 8'h80;
  logic e_busy = 0, e_clr = 0, e_start = 0;
  logic [15:0] e_ld = '0;
  logic [3:0] e_lds = '0;
  logic [1:0] e_op = '0;

  function automatic logic [7:0] lamp(int m, bit er);
    return (m < 4 ? 8'h80 >> m : m == 4 ? 8'h08 : m == 5 ? 8'h02 : 8'h01) | (er ? 8'h04 : 8'h00);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = 0; age = 0; pre = 0; err = 0; res = '0;
      hc = '0; he = '0; hx = '0;
      e_ledr = '0; e_ledg = 8'h80; e_busy = 0; e_clr = 0; e_start = 0;
      e_ld = '0; e_lds = '0; e_op = '0;
    end else begin
      // a press is seen three cycles after the raw rise
      ec = hc[2] & ~hc[3]; ee = he[2] & ~he[3]; ex = hx[2] & ~hx[3];
      hc = {hc[2:0], btn_change}; he = {he[2:0], btn_enter}; hx = {hx[2:0], btn_cancel};
      pm = mode; perr = err; pres = res;
      e_lds = '0; e_clr = 0; e_start = 0;
      if (ex) begin
        e_clr = 1; mode = 0; err = 0; res = '0; pre = 0;
      end else if (mode < 4 && ee) begin
        e_op = sw[1:0];
        if (mode == 3) begin e_lds = 4'b0001; e_ld = sw[17:2]; pre = 1; end
        else begin e_start = 1; age = 1; end
        mode = 4;
      end else if (mode < 4 && ec) begin
        e_lds = 4'b1000 >> mode;
        e_ld = sw[17:2];
        if (mode < 3) mode = mode + 1;
      end else if (mode == 4) begin
        if (pre) begin pre = 0; e_start = 1; age = 1; end
        else if (bus.alu_done) begin res = bus.alu_result; err = 0; mode = 5; end
        else if (age == TMO) begin res = '0; err = 1; mode = 5; end
        else age = age + 1;
      end else if (mode >= 5 && ee) mode = (mode == 5) ? 6 : 5;
      e_busy = mode == 4;
      e_ledg = lamp(pm, perr);
      e_ledr = pm == 4 ? 18'h0 : pm == 5 ? {pres[15:0], sw[1:0]} : pm == 6 ? {pres[31:16], sw[1:0]} : sw;
    end
  end

  always @(negedge clk) begin
    logic [50:0] act, exp;
    act = {ledr, ledg, busy, bus.ld_data, bus.ld_a_lo, bus.ld_a_hi, bus.ld_b_lo, bus.ld_b_hi,
           bus.clr, bus.alu_op, bus.alu_start};
    exp = {e_ledr, e_ledg, e_busy, e_ld, e_lds, e_clr, e_op, e_start};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, act, exp);
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns in the cycle right after the event cycle (strobes visible)
  task automatic push(input bit c, input bit e, input bit x);
    btn_change = c; btn_enter = e; btn_cancel = x;
    tick(); tick();
    btn_change = 0; btn_enter = 0; btn_cancel = 0;
    tick(); tick();
  endtask

  task automatic done(input logic [31:0] r);
    bus.alu_done = 1; bus.alu_result = r;
    tick();
    bus.alu_done = 0; bus.alu_result = '0;
  endtask

  initial begin
    bus.alu_done = 0; bus.alu_result = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ledg", 64'(ledg), 64'h80);
    chk("reset_ledr", 64'(ledr), 64'h0);
    chk("reset_misc", 64'({busy, bus.ld_data, bus.alu_op, bus.alu_start, bus.clr}), 64'h0);
    rst_n = 1;
    tick();
    sw = 18'h0AAA8;
    push(1, 0, 0);
    chk("ld_a_lo_pulse", 64'({bus.ld_a_lo, bus.ld_data}), 64'h1_2AAA);
    chk("ledg_lag", 64'(ledg), 64'h80);
    tick();
    chk("ld_a_lo_once", 64'(bus.ld_a_lo), 64'h0);
    chk("ledg_a_hi", 64'(ledg), 64'h40);
    push(0, 0, 1);
    chk("cancel_clr", 64'(bus.clr), 64'h1);
    sw = {16'h0002, 2'b00}; push(1, 0, 0);
    sw = {16'h0001, 2'b00}; push(1, 0, 0);
    chk("ld_a_hi", 64'({bus.ld_a_hi, bus.ld_data}), 64'h1_0001);
    sw = {16'h0003, 2'b00}; push(1, 0, 0);
    sw = {16'h0000, 2'b01}; push(0, 1, 0);
    chk("enter_b_hi_load", 64'({bus.ld_b_hi, bus.alu_start}), 64'h2);
    tick();
    chk("start_after_ld", 64'({bus.ld_b_hi, bus.alu_start, bus.alu_op}), 64'h5);
    tick();
    done(32'hFFFF_FFFF);
    tick();
    chk("show_l_ledr", 64'(ledr[17:2]), 64'hFFFF);
    chk("show_l_ledg", 64'(ledg), 64'h02);
    push(0, 1, 0);
    tick();
    chk("show_m_ledr", 64'(ledr[17:2]), 64'hFFFF);
    chk("show_m_ledg", 64'(ledg), 64'h01);
    push(0, 0, 1);
    sw = {16'h1234, 2'b10};
    push(0, 1, 0);
    chk("timeout_start", 64'({bus.alu_start, busy}), 64'h3);
    repeat (254) tick();
    chk("timeout_last_busy", 64'(busy), 64'h1);
    tick();
    chk("timeout_fired", 64'(busy), 64'h0);
    tick();
    chk("timeout_ledg", 64'(ledg), 64'h06);
    chk("timeout_ledr", 64'(ledr[17:2]), 64'h0);
    push(0, 0, 1);
    push(0, 1, 0);
    repeat (3) tick();
    push(0, 0, 1);
    chk("cancel_exec", 64'({bus.clr, busy}), 64'h2);
    tick();
    done(32'h1234_5678);
    tick();
    chk("late_done_ledg", 64'(ledg), 64'h80);
    chk("late_done_ledr", 64'(ledr), 64'(sw));
    push(1, 0, 0);
    push(1, 1, 0);
    chk("coincident_no_ld", 64'({bus.ld_a_hi, bus.alu_start, busy}), 64'h3);
    done(32'hABCD_1234);
    tick();
    push(0, 1, 1);
    chk("cancel_beats_enter", 64'({bus.clr, busy}), 64'h2);
    tick();
    chk("cancel_enter_ledg", 64'(ledg), 64'h80);
    sw = {16'h5555, 2'b11};
    push(0, 1, 0);
    done(32'hCAFE_F00D);
    push(0, 1, 0);
    tick();
    chk("pre_reset_ledr", 64'(ledr), 64'({16'hCAFE, 2'b11}));
    #3 rst_n = 0;
    #1;
    chk("async_ledg", 64'(ledg), 64'h80);
    chk("async_ledr", 64'(ledr), 64'h0);
    chk("async_misc", 64'({busy, bus.ld_data, bus.alu_op, bus.alu_start, bus.clr}), 64'h0);
    tick();
    rst_n = 1;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
